// File: rtl/srca_pipe_if.sv
// Handshake bundle for the segmented carry adder pipeline: operand beat in, result beat out.
interface srca_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_approx;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_approx;

    // Upstream/downstream environment side: offers operands and consumes results.
    modport master (
        output in_valid, in_a, in_b, in_cin, in_approx, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_approx
    );

    // Adder side: accepts operands and presents results.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_approx, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_approx
    );
endinterface

// File: rtl/srca_pipe.sv
// Pipelined block-ripple adder with a per-beat approximate mode.
// Block j is summed in stage j; each stage carries the partial sum, the block
// carry, the mode bit and the operand bits still waiting to be added.
// The still-pending operand bits are kept shifted down so the next block to be
// added always sits at the bottom of the operand registers.
module srca_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input logic        clk,
    input logic        rst_n,
    srca_pipe_if.slave bus
);
    localparam int NBLK = WIDTH / BLK;

    // Stage registers, one entry per block.
    logic             r_valid [NBLK];
    logic [WIDTH-1:0] r_sum   [NBLK];
    logic             r_carry [NBLK];
    logic             r_mode  [NBLK];
    logic [WIDTH-1:0] r_opA   [NBLK];
    logic [WIDTH-1:0] r_opB   [NBLK];

    // What each stage would load: predecessor contents or the input port.
    logic             w_srcValid [NBLK];
    logic [WIDTH-1:0] w_srcSum   [NBLK];
    logic             w_srcCarry [NBLK];
    logic             w_srcMode  [NBLK];
    logic [WIDTH-1:0] w_srcA     [NBLK];
    logic [WIDTH-1:0] w_srcB     [NBLK];
    logic [BLK:0]     w_blk      [NBLK];

    logic [NBLK-1:0]  w_en;
    logic             w_chain;

    // One block of ripple cells; in approximate mode the bottom cell ORs the
    // incoming carry into its sum and generates its carry from a&b alone.
    function automatic logic [BLK:0] addBlock(
        input logic [BLK-1:0] a,
        input logic [BLK-1:0] b,
        input logic           cin,
        input logic           approx
    );
        logic [BLK-1:0] s;
        logic           c;
        s = '0;
        c = cin;
        for (int i = 0; i < BLK; i++) begin
            if (i == 0 && approx) begin
                s[i] = (a[i] ^ b[i]) | c;
                c    = a[i] & b[i];
            end else begin
                s[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            end
        end
        return {c, s};
    endfunction

    // Backpressure chain: a stage may load if it is empty or the stage after it moves.
    always_comb begin
        w_en    = '0;
        w_chain = bus.out_ready | ~r_valid[NBLK-1];
        w_en[NBLK-1] = w_chain;
        for (int j = NBLK - 2; j >= 0; j--) begin
            w_chain = ~r_valid[j] | w_chain;
            w_en[j] = w_chain;
        end
    end

    assign bus.in_ready   = w_en[0];
    assign bus.out_valid  = r_valid[NBLK-1];
    assign bus.out_sum    = r_sum[NBLK-1];
    assign bus.out_cout   = r_carry[NBLK-1];
    assign bus.out_approx = r_mode[NBLK-1];

    for (genvar j = 0; j < NBLK; j++) begin : g_stage
        if (j == 0) begin : g_first
            assign w_srcValid[j] = bus.in_valid & w_en[0];
            assign w_srcSum[j]   = '0;
            assign w_srcCarry[j] = bus.in_cin;
            assign w_srcMode[j]  = bus.in_approx;
            assign w_srcA[j]     = bus.in_a;
            assign w_srcB[j]     = bus.in_b;
        end else begin : g_next
            assign w_srcValid[j] = r_valid[j-1];
            assign w_srcSum[j]   = r_sum[j-1];
            assign w_srcCarry[j] = r_carry[j-1];
            assign w_srcMode[j]  = r_mode[j-1];
            assign w_srcA[j]     = r_opA[j-1];
            assign w_srcB[j]     = r_opB[j-1];
        end

        assign w_blk[j] = addBlock(w_srcA[j][BLK-1:0], w_srcB[j][BLK-1:0],
                                   w_srcCarry[j], w_srcMode[j]);

        // Stage j: add block j and advance the beat, or hold while stalled.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid[j] <= 1'b0;
                r_sum[j]   <= '0;
                r_carry[j] <= 1'b0;
                r_mode[j]  <= 1'b0;
                r_opA[j]   <= '0;
                r_opB[j]   <= '0;
            end else if (w_en[j]) begin
                r_valid[j] <= w_srcValid[j];
                r_sum[j]   <= w_srcSum[j] | (WIDTH'(w_blk[j][BLK-1:0]) << (j * BLK));
                r_carry[j] <= w_blk[j][BLK];
                r_mode[j]  <= w_srcMode[j];
                r_opA[j]   <= w_srcA[j] >> BLK;
                r_opB[j]   <= w_srcB[j] >> BLK;
            end
        end
    end
endmodule

// File: tb/tb_srca_pipe.sv
// Scoreboard bench for srca_pipe (WIDTH=8, BLK=4): directed vectors, latency,
// backpressure, mid-flight reset and a mixed-mode stream with random out_ready.
module tb_srca_pipe;
    localparam int WIDTH = 8;
    localparam int BLK   = 4;
    localparam int NBLK  = WIDTH / BLK;

    typedef struct packed {
        logic             approx;
        logic             cout;
        logic [WIDTH-1:0] sum;
    } beat_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             approx;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    beat_t sb[$];
    vec_t  vecs[10];
    int    testsRun    = 0;
    int    testsFailed = 0;
    int    popCount    = 0;
    int    pushCount   = 0;
    beat_t held;
    logic  stallPending = 1'b0;

    always #5 clk = ~clk;

    srca_pipe_if #(.WIDTH(WIDTH)) bus();

    srca_pipe #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Independent reference: exact mode is plain addition; approximate mode
    // treats each block as a special bottom cell plus an exact upper adder.
    function automatic beat_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic cin, input logic approx);
        beat_t          r;
        logic           c;
        logic [BLK-1:0] ba;
        logic [BLK-1:0] bb;
        logic [BLK-1:0] hi;
        logic [BLK:0]   full;
        r = '0;
        c = cin;
        for (int k = 0; k < NBLK; k++) begin
            ba = a[k*BLK +: BLK];
            bb = b[k*BLK +: BLK];
            if (approx) begin
                hi = {1'b0, ba[BLK-1:1]} + {1'b0, bb[BLK-1:1]} + {{(BLK-1){1'b0}}, ba[0] & bb[0]};
                r.sum[k*BLK +: BLK] = {hi[BLK-2:0], (ba[0] ^ bb[0]) | c};
                c = hi[BLK-1];
            end else begin
                full = {1'b0, ba} + {1'b0, bb} + {{BLK{1'b0}}, c};
                r.sum[k*BLK +: BLK] = full[BLK-1:0];
                c = full[BLK];
            end
        end
        r.cout   = c;
        r.approx = approx;
        return r;
    endfunction

    // Offer one beat until accepted (bounded), then record its expected result.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic approx, input beat_t exp);
        int   waitCycles = 0;
        logic accepted   = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_approx = approx;
        while (!accepted && waitCycles < 200) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #2;
            waitCycles++;
        end
        bus.in_valid = 1'b0;
        if (accepted) begin
            sb.push_back(exp);
            pushCount++;
        end else begin
            checkOutput("acceptTimeout", 32'(accepted), 32'(1));
        end
    endtask

    task automatic waitDrain();
        int cycles = 0;
        while (sb.size() != 0 && cycles < 500) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        checkOutput("drainQueue", 32'(sb.size()), 32'(0));
    endtask

    function automatic beat_t vecExp(input int i);
        beat_t r;
        r.approx = vecs[i].approx;
        r.cout   = vecs[i].cout;
        r.sum    = vecs[i].sum;
        return r;
    endfunction

    // Monitor: compare every handed-off beat against the scoreboard and
    // check that a stalled output holds still until it is taken.
    always @(negedge clk) begin
        beat_t exp;
        if (!rst_n) begin
            stallPending <= 1'b0;
        end else begin
            if (stallPending) begin
                checkOutput("stallHold",
                            32'({bus.out_valid, bus.out_approx, bus.out_cout, bus.out_sum}),
                            32'({1'b1, held}));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpectedBeat", 32'(sb.size()), 32'(1));
                end else begin
                    exp = sb.pop_front();
                    checkOutput("sum",    32'(bus.out_sum),    32'(exp.sum));
                    checkOutput("cout",   32'(bus.out_cout),   32'(exp.cout));
                    checkOutput("approx", 32'(bus.out_approx), 32'(exp.approx));
                end
                popCount <= popCount + 1;
            end
            stallPending <= bus.out_valid & ~bus.out_ready;
            held         <= {bus.out_approx, bus.out_cout, bus.out_sum};
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : mainSeq
        int    popBefore;
        int    discarded;
        int    staleSeen;
        logic  streamDone;
        beat_t e;

        vecs[0] = '{8'h18, 8'h08, 1'b0, 1'b0, 8'h20, 1'b0};
        vecs[1] = '{8'h18, 8'h08, 1'b0, 1'b1, 8'h10, 1'b0};
        vecs[2] = '{8'h01, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'hF0, 1'b0};
        vecs[5] = '{8'h1F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0};
        vecs[6] = '{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0};
        vecs[7] = '{8'hF0, 8'hF0, 1'b0, 1'b1, 8'hE0, 1'b1};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1};
        vecs[9] = '{8'h0F, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_approx = 1'b0;
        bus.out_ready = 1'b0;
        discarded     = 0;
        staleSeen     = 0;
        streamDone    = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("rstOutValid", 32'(bus.out_valid),  32'(0));
        checkOutput("rstInReady",  32'(bus.in_ready),   32'(1));
        checkOutput("rstSum",      32'(bus.out_sum),    32'(0));
        checkOutput("rstCout",     32'(bus.out_cout),   32'(0));
        checkOutput("rstApprox",   32'(bus.out_approx), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        $display("[TB] latency check");
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = vecs[0].a;
        bus.in_b      = vecs[0].b;
        bus.in_cin    = vecs[0].cin;
        bus.in_approx = vecs[0].approx;
        @(negedge clk);
        checkOutput("latInReady", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        sb.push_back(vecExp(0));
        pushCount++;
        checkOutput("latAtAccept", 32'(bus.out_valid), 32'(0));
        for (int i = 1; i < NBLK; i++) begin
            @(posedge clk);
            #2;
            checkOutput("latValid", 32'(bus.out_valid), 32'(i == NBLK - 1));
        end
        waitDrain();

        $display("[TB] directed vectors back-to-back");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].approx, vecExp(i));
        end
        waitDrain();

        $display("[TB] full pipeline backpressure");
        bus.out_ready = 1'b0;
        for (int i = 0; i < NBLK; i++) begin
            applyStimulus(vecs[i+3].a, vecs[i+3].b, vecs[i+3].cin, vecs[i+3].approx, vecExp(i+3));
        end
        checkOutput("fullInReady",  32'(bus.in_ready),  32'(0));
        checkOutput("fullOutValid", 32'(bus.out_valid), 32'(1));
        popBefore     = popCount;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("popInReady", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        checkOutput("onePop",        32'(popCount - popBefore), 32'(1));
        checkOutput("afterPopReady", 32'(bus.in_ready),         32'(1));
        repeat (3) @(posedge clk);
        #2;
        checkOutput("stallNoPop", 32'(popCount - popBefore), 32'(1));
        bus.out_ready = 1'b1;
        waitDrain();

        $display("[TB] reset with beats in flight");
        bus.out_ready = 1'b0;
        applyStimulus(vecs[6].a, vecs[6].b, vecs[6].cin, vecs[6].approx, vecExp(6));
        applyStimulus(vecs[7].a, vecs[7].b, vecs[7].cin, vecs[7].approx, vecExp(7));
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 8'h33;
        bus.in_b      = 8'h44;
        bus.in_cin    = 1'b0;
        bus.in_approx = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("midRstOutValid", 32'(bus.out_valid), 32'(0));
        checkOutput("midRstInReady",  32'(bus.in_ready),  32'(1));
        checkOutput("midRstSum",      32'(bus.out_sum),   32'(0));
        discarded     = discarded + sb.size();
        sb.delete();
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) staleSeen++;
        end
        checkOutput("noStaleBeat", 32'(staleSeen), 32'(0));
        @(posedge clk);
        #2;

        $display("[TB] mixed-mode stream with random out_ready");
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    logic [WIDTH-1:0] a;
                    logic [WIDTH-1:0] b;
                    logic             cin;
                    logic             approx;
                    a      = WIDTH'($urandom);
                    b      = WIDTH'($urandom);
                    cin    = 1'($urandom_range(0, 1));
                    approx = (i % 2) == 1;
                    e      = refModel(a, b, cin, approx);
                    applyStimulus(a, b, cin, approx, e);
                end
                streamDone = 1'b1;
            end
            begin
                while (!streamDone) begin
                    @(posedge clk);
                    #2;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        waitDrain();
        @(posedge clk);
        #2;
        checkOutput("beatCount", 32'(popCount), 32'(pushCount - discarded));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
